mario_motion_ctrl: RTL and testbench
====================================

Name: mario_motion_ctrl

Overview:
Parametrised successor to the player coordinate calculator. It moves the character once per frame tick and adds gravity/jump physics, which replaces the externally supplied vertical speed. It clamps both axes to playfield bounds, so position never wraps. It sits between the input decoder (arrow bits) and the sprite renderer (packed coordinate).

Parameters:
W, 16, width of one axis coordinate (unsigned, screen space, y grows downward)
X_MIN, 0, left bound of x
X_MAX, 608, right bound of x
Y_MIN, 0, ceiling bound of y
Y_FLOOR, 400, floor y (ground level)
X_INIT, 320, x after reset
Y_INIT, 100, y after reset (must satisfy Y_MIN <= Y_INIT <= Y_FLOOR)
GRAVITY, 1, vertical velocity change per tick
JUMP_V, 10, initial upward velocity of a jump
VMAX_FALL, 8, terminal falling velocity

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-low reset (sampled on rising clk)
tick  input  1  frame enable; state advances only on cycles where tick=1
move_arrow  input  4  [3]=up/jump, [2]=down/crouch, [1]=left, [0]=right
speed_x  input  W  horizontal step per tick (unsigned)
coordinate  output  2W  {x[2W-1:W], y[W-1:0]}, registered
vy  output  W  current vertical speed magnitude, registered
motion_state  output  2  GROUND=0, RISING=1, FALLING=2
crouch  output  1  registered; 1 when in GROUND with down held at last tick
hit_wall  output  1  one-cycle pulse on a tick where x was clamped
landed  output  1  one-cycle pulse on the tick that enters GROUND

Behaviour:
- Reset (rst=0 at clk edge): x=X_INIT, y=Y_INIT, vy=0, crouch=0, hit_wall=0, landed=0, jump_armed=1. motion_state=GROUND if Y_INIT==Y_FLOOR, else FALLING. Reset wins over tick.
- tick=0: all registers hold; hit_wall/landed return to 0 the cycle after they pulse.
- All updates land on the clk edge where tick=1, giving one-tick latency from move_arrow to coordinate.
- Horizontal: left has priority over right; neither bit set means x holds. The sum x±speed_x is computed in W+1 bits signed, then clamped to [X_MIN, X_MAX]. hit_wall=1 if clamping changed the result. Horizontal motion is allowed in every state.
- jump_armed: cleared on jump start; set on any tick with up=0. This makes jump edge-triggered, so holding up does not re-jump.
- GROUND: y=Y_FLOOR, vy=0. On a tick with up=1 and jump_armed=1: vy<=JUMP_V, state<=RISING, y unchanged. crouch<=down & ~jump-start.
- RISING: y<=max(y-vy, Y_MIN). If y-vy<Y_MIN (ceiling hit) or vy<=GRAVITY, then state<=FALLING and vy<=0; otherwise vy<=vy-GRAVITY. crouch=0.
- FALLING: y_next=y+vy. If y_next>=Y_FLOOR, then y<=Y_FLOOR, vy<=0, state<=GROUND, landed=1. Otherwise y<=y_next and vy<=min(vy+GRAVITY, VMAX_FALL). Up is ignored.
- Illegal state code 3: treated as FALLING on the next tick.
- All vertical intermediate arithmetic uses W+1 bits, so no wrap-around is possible.

Decomposition:
- Package mario_motion_pkg holds the state encodings (GROUND/RISING/FALLING), arrow bit indices (ARW_UP=3, ARW_DOWN=2, ARW_LEFT=1, ARW_RIGHT=0), and the coordinate packing helper constants.
- One sub-module, mario_axis_clamp: a combinational saturating add/sub of W-bit value ± W-bit step with bounds [lo, hi], producing the result and a clamped flag. It is instantiated for x and for the y ceiling/floor checks.

Test Plan:
- Reset then 8 ticks, no input -> coordinate {320,100}, FALLING, vy=0 after reset; y sequence 100,101,103,106,110,115,121,128 with vy reaching 8; later ticks add 8 per tick.
- Settle at the floor (y=400, GROUND), then up pulsed for 1 tick -> vy=10, RISING, y=400. Next ticks give y=390,381,373,366,360,355,351,348,346,345; FALLING with vy=0 at the 345 tick; later returns to 400 with a single landed pulse.
- Wall clamp: x=600, right, speed_x=16 -> x=608, hit_wall one cycle. Then x=5, left, speed_x=16 -> x=0, hit_wall. Left and right both set at x=320, speed_x=4 -> x=316.
- tick=0 for 20 cycles with arrows toggling -> coordinate, vy and state unchanged; no pulses.
- Up held continuously through a jump and landing -> exactly one jump; after up is released for one tick and pressed again, a second jump starts. Down held in GROUND -> crouch=1, x still moves.
- rst=0 asserted mid-RISING (y=366) -> on that edge coordinate={320,100}, FALLING, vy=0, all pulses 0, regardless of tick.

Source files
------------

// File: rtl/mario_motion_pkg.sv
// Shared encodings for the player motion controller: motion states, arrow bit
// positions and the slot layout of the packed coordinate output.
package mario_motion_pkg;

  typedef enum logic [1:0] {
    GROUND  = 2'd0,
    RISING  = 2'd1,
    FALLING = 2'd2
  } motion_t;

  localparam int unsigned ARW_UP    = 3;
  localparam int unsigned ARW_DOWN  = 2;
  localparam int unsigned ARW_LEFT  = 1;
  localparam int unsigned ARW_RIGHT = 0;

  // coordinate = {x, y}: slot index times W gives the LSB of each axis
  localparam int unsigned COORD_X_SLOT = 1;
  localparam int unsigned COORD_Y_SLOT = 0;

endpackage

// File: rtl/mario_axis_clamp.sv
// Combinational saturating value +/- step, clamped to [lo, hi] with a flag
// that reports whether saturation changed the result.
module mario_axis_clamp #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] step,
  input  logic         sub,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  output logic [W-1:0] result,
  output logic         clamped
);

  // two guard bits: one for carry out of the add, one for the sign of the sub
  logic signed [W+1:0] sum;
  logic signed [W+1:0] lo_e;
  logic signed [W+1:0] hi_e;

  always_comb begin
    lo_e = $signed({2'b00, lo});
    hi_e = $signed({2'b00, hi});
    if (sub) begin
      sum = $signed({2'b00, value}) - $signed({2'b00, step});
    end else begin
      sum = $signed({2'b00, value}) + $signed({2'b00, step});
    end
    result  = sum[W-1:0];
    clamped = 1'b0;
    if (sum < lo_e) begin
      result  = lo;
      clamped = 1'b1;
    end else if (sum > hi_e) begin
      result  = hi;
      clamped = 1'b1;
    end
  end

endmodule

// File: rtl/mario_motion_ctrl.sv
// Per-frame player motion: clamped horizontal stepping plus jump/gravity
// physics, producing a registered packed coordinate for the sprite renderer.
module mario_motion_ctrl
  import mario_motion_pkg::*;
#(
  parameter int unsigned W         = 16,
  parameter int unsigned X_MIN     = 0,
  parameter int unsigned X_MAX     = 608,
  parameter int unsigned Y_MIN     = 0,
  parameter int unsigned Y_FLOOR   = 400,
  parameter int unsigned X_INIT    = 320,
  parameter int unsigned Y_INIT    = 100,
  parameter int unsigned GRAVITY   = 1,
  parameter int unsigned JUMP_V    = 10,
  parameter int unsigned VMAX_FALL = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic [3:0]     move_arrow,
  input  logic [W-1:0]   speed_x,
  output logic [2*W-1:0] coordinate,
  output logic [W-1:0]   vy,
  output logic [1:0]     motion_state,
  output logic           crouch,
  output logic           hit_wall,
  output logic           landed
);

  localparam logic [W-1:0] XMIN_V   = W'(X_MIN);
  localparam logic [W-1:0] XMAX_V   = W'(X_MAX);
  localparam logic [W-1:0] YMIN_V   = W'(Y_MIN);
  localparam logic [W-1:0] FLOOR_V  = W'(Y_FLOOR);
  localparam logic [W-1:0] JUMP_VV  = W'(JUMP_V);
  localparam logic [W-1:0] GRAV_V   = W'(GRAVITY);
  localparam logic [W:0]   GRAV_E   = (W+1)'(GRAVITY);
  localparam logic [W:0]   VMAX_E   = (W+1)'(VMAX_FALL);
  localparam motion_t      RESET_ST = (Y_INIT == Y_FLOOR) ? GROUND : FALLING;

  motion_t      state_q, state_d;
  logic [W-1:0] x_q, x_d, y_q, y_d, vy_q, vy_d;
  logic         crouch_q, crouch_d, hit_q, hit_d, landed_q, landed_d;
  logic         armed_q, armed_d;

  logic         up, down, left, right, horiz, jump_start;
  logic [W-1:0] x_step, x_res, y_res;
  logic         x_clamped, y_clamped;
  logic [W:0]   vy_inc;

  assign up    = move_arrow[ARW_UP];
  assign down  = move_arrow[ARW_DOWN];
  assign left  = move_arrow[ARW_LEFT];
  assign right = move_arrow[ARW_RIGHT];
  assign horiz = left | right;

  // left wins over right by driving the subtract select from left alone
  assign x_step = horiz ? speed_x : '0;

  mario_axis_clamp #(.W(W)) u_x_clamp (
    .value   (x_q),
    .step    (x_step),
    .sub     (left),
    .lo      (XMIN_V),
    .hi      (XMAX_V),
    .result  (x_res),
    .clamped (x_clamped)
  );

  // rising checks the ceiling (y - vy), any other state checks the floor (y + vy)
  mario_axis_clamp #(.W(W)) u_y_clamp (
    .value   (y_q),
    .step    (vy_q),
    .sub     (state_q == RISING),
    .lo      (YMIN_V),
    .hi      (FLOOR_V),
    .result  (y_res),
    .clamped (y_clamped)
  );

  assign vy_inc = {1'b0, vy_q} + GRAV_E;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RESET_ST;
      x_q      <= W'(X_INIT);
      y_q      <= W'(Y_INIT);
      vy_q     <= '0;
      crouch_q <= 1'b0;
      hit_q    <= 1'b0;
      landed_q <= 1'b0;
      armed_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vy_q     <= vy_d;
      crouch_q <= crouch_d;
      hit_q    <= hit_d;
      landed_q <= landed_d;
      armed_q  <= armed_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    vy_d       = vy_q;
    crouch_d   = crouch_q;
    armed_d    = armed_q;
    hit_d      = 1'b0;
    landed_d   = 1'b0;
    jump_start = 1'b0;
    if (tick) begin
      x_d   = x_res;
      hit_d = x_clamped;
      case (state_q)
        GROUND: begin
          y_d  = FLOOR_V;
          vy_d = '0;
          if (up && armed_q) begin
            jump_start = 1'b1;
            vy_d       = JUMP_VV;
            state_d    = RISING;
          end
          crouch_d = down & ~jump_start;
        end
        RISING: begin
          y_d      = y_res;
          crouch_d = 1'b0;
          if (y_clamped || ({1'b0, vy_q} <= GRAV_E)) begin
            state_d = FALLING;
            vy_d    = '0;
          end else begin
            vy_d = vy_q - GRAV_V;
          end
        end
        default: begin
          crouch_d = 1'b0;
          if (y_clamped || (y_res == FLOOR_V)) begin
            y_d      = FLOOR_V;
            vy_d     = '0;
            state_d  = GROUND;
            landed_d = 1'b1;
          end else begin
            y_d  = y_res;
            vy_d = (vy_inc > VMAX_E) ? VMAX_E[W-1:0] : vy_inc[W-1:0];
          end
        end
      endcase
      if (jump_start) begin
        armed_d = 1'b0;
      end else if (!up) begin
        armed_d = 1'b1;
      end
    end
  end

  always_comb begin
    coordinate                        = '0;
    coordinate[COORD_X_SLOT*W +: W]   = x_q;
    coordinate[COORD_Y_SLOT*W +: W]   = y_q;
    vy           = vy_q;
    motion_state = state_q;
    crouch       = crouch_q;
    hit_wall     = hit_q;
    landed       = landed_q;
  end

endmodule

// File: tb/tb_mario_motion_ctrl.sv
// Scoreboard bench for mario_motion_ctrl: a reference model pushes expected
// outputs per driven cycle; a monitor pops and compares after each edge.
module tb_mario_motion_ctrl;
  import mario_motion_pkg::*;

  localparam int W = 16;
  localparam int XMIN = 0, XMAX = 608, YMIN = 0, YFLR = 400;
  localparam int XINI = 320, YINI = 100, GRAV = 1, JMPV = 10, VMAX = 8;

  typedef struct {
    logic [2*W-1:0] coord;
    logic [W-1:0]   vy;
    logic [1:0]     st;
    logic           cr;
    logic           hw;
    logic           ld;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           tick;
  logic [3:0]     move_arrow;
  logic [W-1:0]   speed_x;
  logic [2*W-1:0] coordinate;
  logic [W-1:0]   vy;
  logic [1:0]     motion_state;
  logic           crouch;
  logic           hit_wall;
  logic           landed;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int mx, my, mvy, mst, mcr, mhw, mld, marm;

  mario_motion_ctrl #(.W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .move_arrow   (move_arrow),
    .speed_x      (speed_x),
    .coordinate   (coordinate),
    .vy           (vy),
    .motion_state (motion_state),
    .crouch       (crouch),
    .hit_wall     (hit_wall),
    .landed       (landed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit t, input logic [3:0] a, input int sp);
    int  nx, ny;
    bit  jump;
    jump = 1'b0;
    if (!r) begin
      mx = XINI; my = YINI; mvy = 0; mcr = 0; mhw = 0; mld = 0; marm = 1;
      mst = (YINI == YFLR) ? 0 : 2;
    end else if (!t) begin
      mhw = 0;
      mld = 0;
    end else begin
      nx = mx;
      if (a[1]) nx = mx - sp;
      else if (a[0]) nx = mx + sp;
      mhw = 0;
      if (nx < XMIN) begin nx = XMIN; mhw = 1; end
      if (nx > XMAX) begin nx = XMAX; mhw = 1; end
      mx  = nx;
      mld = 0;
      if (mst == 0) begin
        my = YFLR;
        mvy = 0;
        if (a[3] && marm) begin
          mvy = JMPV; mst = 1; jump = 1'b1;
        end
        mcr = (a[2] && !jump) ? 1 : 0;
      end else if (mst == 1) begin
        mcr = 0;
        ny = my - mvy;
        if (ny < YMIN || mvy <= GRAV) begin
          mst = 2;
          my  = (ny < YMIN) ? YMIN : ny;
          mvy = 0;
        end else begin
          my  = ny;
          mvy = mvy - GRAV;
        end
      end else begin
        mcr = 0;
        ny = my + mvy;
        if (ny >= YFLR) begin
          my = YFLR; mvy = 0; mst = 0; mld = 1;
        end else begin
          my  = ny;
          mvy = (mvy + GRAV > VMAX) ? VMAX : mvy + GRAV;
        end
      end
      if (jump) marm = 0;
      else if (!a[3]) marm = 1;
    end
  endtask

  task automatic drive(input bit r, input bit t, input logic [3:0] a, input int sp);
    exp_t e;
    @(negedge clk);
    rst        = r;
    tick       = t;
    move_arrow = a;
    speed_x    = W'(sp);
    model_step(r, t, a, sp);
    e.coord = {W'(mx), W'(my)};
    e.vy    = W'(mvy);
    e.st    = 2'(mst);
    e.cr    = mcr[0];
    e.hw    = mhw[0];
    e.ld    = mld[0];
    sb.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("coord",  coordinate,   e.coord);
        check("vy",     vy,           e.vy);
        check("state",  motion_state, e.st);
        check("crouch", crouch,       e.cr);
        check("hit",    hit_wall,     e.hw);
        check("landed", landed,       e.ld);
      end
    end
  end

  initial begin
    int rise_y[10];
    int n_land;
    rise_y = '{390, 381, 373, 366, 360, 355, 351, 348, 346, 345};
    rst = 1'b1; tick = 1'b0; move_arrow = '0; speed_x = '0;

    drive(0, 0, 4'b0000, 0);
    drive(0, 1, 4'b0000, 0);
    after_edge();
    check("rst_coord", coordinate, {16'd320, 16'd100});
    check("rst_state", motion_state, 2'(FALLING));
    check("rst_vy", vy, 0);

    for (int i = 0; i < 8; i++) drive(1, 1, 4'b0000, 0);
    after_edge();
    check("fall8_y", coordinate[W-1:0], 128);
    check("fall8_vy", vy, 8);
    drive(1, 1, 4'b0000, 0);
    after_edge();
    check("fall9_y", coordinate[W-1:0], 136);

    for (int i = 0; i < 200 && mst != 0; i++) drive(1, 1, 4'b0000, 0);
    after_edge();
    check("floor_y", coordinate[W-1:0], 400);
    check("floor_state", motion_state, 2'(GROUND));

    drive(1, 1, 4'b1000, 0);
    after_edge();
    check("jump_vy", vy, 10);
    check("jump_state", motion_state, 2'(RISING));
    check("jump_y", coordinate[W-1:0], 400);
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 4'b0000, 0);
      after_edge();
      check("rise_y", coordinate[W-1:0], 64'(rise_y[i]));
    end
    check("apex_state", motion_state, 2'(FALLING));
    check("apex_vy", vy, 0);
    n_land = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1, 1, 4'b0000, 0);
      after_edge();
      if (landed) n_land++;
    end
    check("land_count", 64'(n_land), 1);

    for (int i = 0; i < 20; i++) drive(1, 0, 4'($urandom()), int'($urandom_range(0, 50)));
    after_edge();
    check("hold_coord", coordinate, {16'd320, 16'd400});

    drive(1, 1, 4'b0001, 280);
    drive(1, 1, 4'b0001, 16);
    after_edge();
    check("wall_r_x", coordinate[2*W-1:W], 608);
    check("wall_r_hit", hit_wall, 1);
    drive(1, 1, 4'b0010, 603);
    drive(1, 1, 4'b0010, 16);
    after_edge();
    check("wall_l_x", coordinate[2*W-1:W], 0);
    check("wall_l_hit", hit_wall, 1);
    drive(1, 1, 4'b0001, 320);
    drive(1, 1, 4'b0011, 4);
    after_edge();
    check("both_x", coordinate[2*W-1:W], 316);

    for (int i = 0; i < 40; i++) drive(1, 1, 4'b1000, 0);
    after_edge();
    check("held_state", motion_state, 2'(GROUND));
    drive(1, 1, 4'b0000, 0);
    drive(1, 1, 4'b1000, 0);
    after_edge();
    check("rejump_state", motion_state, 2'(RISING));
    for (int i = 0; i < 200 && mst != 0; i++) drive(1, 1, 4'b0000, 0);
    drive(1, 1, 4'b0101, 2);
    after_edge();
    check("crouch", crouch, 1);
    check("crouch_x", coordinate[2*W-1:W], 318);

    drive(1, 1, 4'b1000, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 4'b0000, 0);
    after_edge();
    check("mid_y", coordinate[W-1:0], 366);
    drive(0, 1, 4'b1001, 9);
    after_edge();
    check("mid_rst_coord", coordinate, {16'd320, 16'd100});
    check("mid_rst_state", motion_state, 2'(FALLING));
    check("mid_rst_vy", vy, 0);
    drive(0, 0, 4'b0000, 0);
    drive(1, 1, 4'b0000, 0);
    after_edge();
    #5;
    check("sb_drain", 64'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
